// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline types and constants for the hazard controller.
package riscv_pipe_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic [1:0] {
        RUN,
        FREEZE,
        FETCH_WAIT
    } pipe_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: synchronous-clear up counter that holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        count_q <= clear_i ? '0 : (inc_i && count_q != '1) ? count_q + 1'b1 : count_q;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for the 5-stage pipeline registers,
// resolving load-use, taken branches, fetch waits and data-memory freezes.
module pipe_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_uses_rs2_i,
    input  logic                 ex_mem_read_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 mem_branch_taken_i,
    input  logic                 imem_ready_i,
    input  logic                 dmem_busy_i,
    output logic                 pc_write_o,
    output logic                 if_id_write_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_write_o,
    output logic                 id_ex_flush_o,
    output logic                 ex_mem_flush_o,
    output logic                 pc_sel_branch_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    pipe_state_e state_q, state_d;
    logic        br_pend_q, br_pend_d;
    logic        drop_q, drop_d;
    logic        lu, branch;

    assign lu = ex_mem_read_i && ex_rd_i != '0 &&
                (ex_rd_i == id_rs1_i || (id_uses_rs2_i && ex_rd_i == id_rs2_i));
    assign branch = mem_branch_taken_i || br_pend_q;

    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_write_o   = 1'b1;
        id_ex_flush_o   = 1'b0;
        ex_mem_flush_o  = 1'b0;
        pc_sel_branch_o = 1'b0;
        state_d         = RUN;
        br_pend_d       = br_pend_q;
        drop_d          = drop_q;
        if (reset) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            br_pend_d      = 1'b0;
            drop_d         = 1'b0;
        end else if (dmem_busy_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_write_o = 1'b0;
            state_d       = FREEZE;
            br_pend_d     = br_pend_q || mem_branch_taken_i;
        end else if (branch) begin
            // An in-flight fetch belongs to the wrong path; its ready pulse is discarded later.
            pc_sel_branch_o = 1'b1;
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            ex_mem_flush_o  = 1'b1;
            br_pend_d       = 1'b0;
            drop_d          = !imem_ready_i;
            state_d         = imem_ready_i ? RUN : FETCH_WAIT;
        end else if (lu && state_q != FETCH_WAIT) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
        end else if (!imem_ready_i) begin
            pc_write_o    = 1'b0;
            if_id_flush_o = 1'b1;
            state_d       = FETCH_WAIT;
        end else if (drop_q) begin
            pc_write_o    = 1'b0;
            if_id_flush_o = 1'b1;
            drop_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        br_pend_q <= br_pend_d;
        drop_q    <= drop_d;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .inc_i   (!reset && !pc_write_o),
        .clear_i (reset),
        .count_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .inc_i   (!reset && !dmem_busy_i && branch),
        .clear_i (reset),
        .count_o (flush_cnt_o)
    );

endmodule
